router_out_arbiter: RTL and testbench
=====================================

ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 SHALL have parameter PKT_FLITS, default 4, flits per packet (legal 1..8).
REQ-002 SHALL have parameter WDOG_CYCLES, default 16, stall limit in cycles (legal 2..255; used only with ARB_WATCHDOG_EN).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  5  per-input "FIFO non-empty", bit0=N, 1=E, 2=S, 3=W, 4=Local.
REQ-006 SHALL have port in_data  input  40  input FIFO data_out buses, bits [8i+7:8i] from input i.
REQ-007 SHALL have port out_ready  input  1  downstream can accept one flit this cycle.
REQ-008 SHALL have port rd  output  5  read strobes to input FIFOs, at most one bit high.
REQ-009 SHALL have port grant  output  5  registered one-hot owner of the output port, 0 when idle.
REQ-010 SHALL have port out_data  output  8  flit to downstream.
REQ-011 SHALL have port out_write  output  1  out_data valid, write strobe to downstream.
REQ-012 SHALL have port abort  output  1  one-cycle pulse on watchdog abort.

Function
REQ-013 SHALL implement FSM with states IDLE and XFER only.
REQ-014 IDLE: if req!=0, SHALL select winner round-robin, search starting at ptr+1 mod 5, register grant=one-hot(winner), go XFER; else stay IDLE, grant=0.
REQ-015 rd[g] SHALL be combinational: high iff state==XFER, grant[g], req[g] and out_ready; all other rd bits 0.
REQ-016 Each cycle rd!=0 SHALL increment flit counter (4 bits); counter frozen when rd==0.
REQ-017 The cycle rd issues flit number PKT_FLITS (counter==PKT_FLITS-1 with rd high) SHALL transition to IDLE, set ptr=g, clear counter and grant.
REQ-018 out_write SHALL be a register equal to |rd of the previous cycle (latency 1, matching FIFO registered read).
REQ-019 out_data SHALL equal in_data slice of the source index registered alongside out_write; out_data holds last value when out_write=0.
REQ-020 At least one IDLE cycle SHALL separate consecutive packets; packets from different inputs SHALL never interleave.
REQ-021 req dropping mid-packet or out_ready low SHALL stall (no rd, no count change) while grant is held.
REQ-022 req changes of non-granted inputs during XFER SHALL have no effect.
REQ-023 Winner search wraps 4->0; single requester SHALL win repeatedly regardless of ptr.

Reset
REQ-024 On rst high at a clock edge: state=IDLE, grant=0, ptr=4 (input 0 highest first priority), counter=0, stall counter=0, out_write=0, out_data=0, abort=0.
REQ-025 rd SHALL be 0 during any cycle rst is high; reset mid-packet discards remaining flits without further reads.

Configuration
REQ-026 Macro ARB_WATCHDOG_EN defined: stall counter increments each XFER cycle with rd==0, clears on rd!=0; on reaching WDOG_CYCLES SHALL pulse abort one cycle, return IDLE, set ptr=g, clear counters and grant.
REQ-027 Macro ARB_WATCHDOG_EN undefined: no stall counter, grant held indefinitely, abort tied 0; WDOG_CYCLES ignored.

Verification
REQ-028 Reset, req=5'b00001, out_ready=1, in_data[7:0] yields A1..A4 -> grant=00001 one cycle after req, rd[0] high 4 cycles, out_write 4 cycles delayed 1, out_data A1..A4, then IDLE.
REQ-029 req=5'b11111 held, out_ready=1 -> packet grant order 0,1,2,3,4,0; each 4 flits; one IDLE gap between.
REQ-030 Granted input 2, out_ready low 3 cycles after flit 2 -> rd=0 those cycles, counter holds, flits 3-4 follow, total exactly 4 out_write pulses.
REQ-031 rst asserted after flit 2 of input 3 -> next cycle grant=0, rd=0, out_write=0; next arbitration starts at input 0.
REQ-032 ARB_WATCHDOG_EN, WDOG_CYCLES=16, input 1 req drops after flit 1 -> abort pulses after 16 stalled cycles, next grant goes to input 2 if requesting.
REQ-033 ARB_WATCHDOG_EN undefined, same stimulus -> grant stays 00010 for 100 cycles, abort=0; flits 2-4 delivered when req returns.

Source files
------------

// File: rtl/router_out_arbiter.sv
// Five-input round-robin output-port arbiter for a mesh router: whole-packet grants, 1-cycle read latency.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module router_out_arbiter #(
    parameter int PKT_FLITS   = 4,
    parameter int WDOG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [39:0] in_data,
    input  logic        out_ready,
    output logic [4:0]  rd,
    output logic [4:0]  grant,
    output logic [7:0]  out_data,
    output logic        out_write,
    output logic        abort
);
    localparam logic IDLE = 1'b0;
    localparam logic XFER = 1'b1;

    logic            state;
    logic [2:0]      ptr;
    logic [2:0]      cur;
    logic [3:0]      cnt;
    logic [2:0]      win;
    logic            found;
    logic [4:0][7:0] in_lane;

    for (genvar i = 0; i < 5; i++) begin : g_lane
        assign in_lane[i] = in_data[8*i +: 8];
    end

    // Empty on legal settings; elaborates only when a parameter is out of range.
    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255 || PKT_FLITS < 1 || PKT_FLITS > 8) begin : g_param_range_bad
    end

    function automatic logic [2:0] wrap5(input logic [2:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= 5) s = s - 5;
        return 3'(s);
    endfunction

    // Search ptr+1 .. ptr+5 so the last owner has lowest priority and a lone requester always wins.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (!found && req[wrap5(ptr, k)]) begin
                found = 1'b1;
                win   = wrap5(ptr, k);
            end
        end
    end

    assign rd = (!rst && state == XFER && out_ready) ? (grant & req) : 5'b0;

`ifdef ARB_WATCHDOG_EN
    logic [7:0] stall;
    logic       wdog_hit;

    assign wdog_hit = (state == XFER) && (rd == 5'b0) && (stall == 8'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall <= 8'd0;
            abort <= 1'b0;
        end else begin
            abort <= wdog_hit;
            if (state == XFER && rd == 5'b0 && !wdog_hit)
                stall <= stall + 8'd1;
            else
                stall <= 8'd0;
        end
    end
`else
    logic wdog_hit;

    assign wdog_hit = 1'b0;
    assign abort    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 5'b0;
            ptr       <= 3'd4;
            cur       <= 3'd0;
            cnt       <= 4'd0;
            out_write <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            out_write <= |rd;
            if (|rd) out_data <= in_lane[cur];
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= 5'b1 << win;
                        cur   <= win;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (|rd) begin
                        if (cnt == 4'(PKT_FLITS - 1)) begin
                            state <= IDLE;
                            ptr   <= cur;
                            cnt   <= 4'd0;
                            grant <= 5'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (wdog_hit) begin
                        state <= IDLE;
                        ptr   <= cur;
                        cnt   <= 4'd0;
                        grant <= 5'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: single packet, full round-robin, back-pressure, reset, stall.
module tb_router_out_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [39:0] in_data;
    logic        out_ready;
    logic [4:0]  rd;
    logic [4:0]  grant;
    logic [7:0]  out_data;
    logic        out_write;
    logic        abort;

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;

    router_out_arbiter #(.PKT_FLITS(4), .WDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .out_ready(out_ready),
        .rd(rd), .grant(grant), .out_data(out_data), .out_write(out_write), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (out_write) wcnt++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wcnt = 0;
    endtask

    initial begin
        rst = 1'b1; req = 5'b0; in_data = 40'd0; out_ready = 1'b0;

        // reset state
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owr", 32'(out_write), 32'h0);
        chk("rst_odata", 32'(out_data), 32'h0);
        chk("rst_abort", 32'(abort), 32'h0);
        req = 5'b00001; rst = 1'b1; settle();
        chk("rst_rd", 32'(rd), 32'h0);
        tick(); rst = 1'b0;

        // single packet from input 0, A1..A4
        req = 5'b00001; out_ready = 1'b1; in_data[7:0] = 8'hA1;
        tick();
        chk("p0_grant", 32'(grant), 32'h01);
        for (int i = 0; i < 4; i++) begin
            chk("p0_rd", 32'(rd), 32'h01);
            tick();
            chk("p0_owr", 32'(out_write), 32'h1);
            chk("p0_odata", 32'(out_data), 32'(8'hA1 + i));
            in_data[7:0] = 8'(8'hA2 + i);
            settle();
        end
        chk("p0_idle_grant", 32'(grant), 32'h0);
        chk("p0_idle_rd", 32'(rd), 32'h0);
        req = 5'b0;
        tick();
        chk("p0_owr_off", 32'(out_write), 32'h0);
        chk("p0_hold", 32'(out_data), 32'hA4);

        // all inputs requesting: order 0,1,2,3,4,0 with an idle gap between packets
        do_reset();
        in_data = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
        req = 5'b11111; out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(5'b1 << (p % 5)));
            for (int f = 0; f < 4; f++) begin
                chk("rr_rd", 32'(rd), 32'(5'b1 << (p % 5)));
                tick();
                chk("rr_odata", 32'(out_data), 32'(8'hC0 + (p % 5)));
            end
            chk("rr_gap", 32'(grant), 32'h0);
        end
        tick();
        chk("rr_wcnt", 32'(wcnt), 32'd24);

        // input 2 with 3 cycles of back-pressure after flit 2
        do_reset();
        req = 5'b00100; out_ready = 1'b1;
        tick();
        chk("bp_grant", 32'(grant), 32'h04);
        tick();
        tick();
        out_ready = 1'b0; settle();
        chk("bp_rd_low", 32'(rd), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_rd", 32'(rd), 32'h0);
            chk("bp_stall_grant", 32'(grant), 32'h04);
        end
        out_ready = 1'b1; settle();
        chk("bp_f3_rd", 32'(rd), 32'h04);
        tick();
        chk("bp_f4_rd", 32'(rd), 32'h04);
        tick();
        chk("bp_done_grant", 32'(grant), 32'h0);
        req = 5'b0;
        tick();
        tick();
        chk("bp_wcnt", 32'(wcnt), 32'd4);

        // reset mid-packet from input 3 (ptr is 2 here, so a missing ptr reset would pick 3 next)
        req = 5'b01000;
        tick();
        chk("mr_grant", 32'(grant), 32'h08);
        tick();
        tick();
        rst = 1'b1; settle();
        chk("mr_rd_in_rst", 32'(rd), 32'h0);
        tick();
        chk("mr_grant0", 32'(grant), 32'h0);
        chk("mr_owr0", 32'(out_write), 32'h0);
        rst = 1'b0; req = 5'b01001;
        tick();
        chk("mr_next", 32'(grant), 32'h01);
        req = 5'b00001;
        tick(); tick(); tick(); tick();
        chk("mr_end", 32'(grant), 32'h0);

        // input 1 drops req after flit 1, input 2 starts requesting
        do_reset();
        req = 5'b00010; out_ready = 1'b1;
        tick();
        chk("wd_grant", 32'(grant), 32'h02);
        tick();
        req = 5'b00100; settle();
        chk("wd_rd0", 32'(rd), 32'h0);
`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wd_wait_abort", 32'(abort), 32'h0);
            chk("wd_wait_grant", 32'(grant), 32'h02);
        end
        tick();
        chk("wd_abort", 32'(abort), 32'h1);
        chk("wd_abort_grant", 32'(grant), 32'h0);
        tick();
        chk("wd_abort_off", 32'(abort), 32'h0);
        chk("wd_next", 32'(grant), 32'h04);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 25 == 24) begin
                chk("hold_grant", 32'(grant), 32'h02);
                chk("hold_abort", 32'(abort), 32'h0);
                chk("hold_rd", 32'(rd), 32'h0);
            end
        end
        req = 5'b00110; settle();
        for (int i = 0; i < 3; i++) begin
            chk("hold_resume_rd", 32'(rd), 32'h02);
            tick();
        end
        chk("hold_done", 32'(grant), 32'h0);
        chk("hold_wcnt", 32'(wcnt), 32'd4);
        tick();
        chk("hold_next", 32'(grant), 32'h04);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
